// File: rtl/run_ctrl.sv
// Run/step/halt sequencer for a pipelined core: broadcasts exec/idle to all stages,
// stops on breakpoints or a HALT in WB, and counts exec cycles and retired instructions.
//   state   | meaning
//   IDLE    | paused, waits for start or step
//   RUN     | free-running exec
//   STEP    | single exec cycle, then IDLE or HALTED
//   HALTED  | HALT retired; left only by reset
module run_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        step_i,
  input  logic        bp_en_i,
  input  logic [7:0]  bp_addr_i,
  input  logic [7:0]  i_addr_i,
  input  logic [15:0] wb_ir_i,
  output logic        state_o,
  output logic        halted_o,
  output logic        bp_hit_o,
  output logic [15:0] cycle_cnt_o,
  output logic [15:0] instr_cnt_o
);

  localparam logic       ST_EXEC = 1'b1;
  localparam logic       ST_IDLE = 1'b0;
  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_HALT = 5'h1F;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        first_exec_q, first_exec_d;
  logic        bp_hit_q, bp_hit_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;

  logic [4:0]  wb_op;
  logic        is_halt;
  logic        is_nop;
  logic        bp_match;
  logic        exec;
  logic        unused_ir;

  assign wb_op     = wb_ir_i[15:11];
  assign is_halt   = (wb_op == OP_HALT);
  assign is_nop    = (wb_op == OP_NOP);
  assign bp_match  = bp_en_i && (i_addr_i == bp_addr_i);
  assign unused_ir = ^wb_ir_i[10:0];

  // Decoded from the state register only, so reset forces idle without an edge.
  assign exec = (state_q == S_RUN) || (state_q == S_STEP);

  always_comb begin
    state_d      = state_q;
    first_exec_d = 1'b0;
    bp_hit_d     = bp_hit_q;
    case (state_q)
      S_IDLE: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (start_i) begin
          state_d      = S_RUN;
          first_exec_d = 1'b1;
          bp_hit_d     = 1'b0;
        end else if (step_i) begin
          state_d  = S_STEP;
          bp_hit_d = 1'b0;
        end
      end
      S_RUN: begin
        // first_exec masks the breakpoint so a resume can leave the stopped address.
        if (is_halt) begin
          state_d = S_HALTED;
        end else if (stop_i) begin
          state_d = S_IDLE;
        end else if (bp_match && !first_exec_q) begin
          state_d  = S_IDLE;
          bp_hit_d = 1'b1;
        end
      end
      S_STEP: begin
        state_d = is_halt ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cycle_cnt_d = cycle_cnt_q + {15'd0, exec};
  assign instr_cnt_d = instr_cnt_q + {15'd0, exec && !is_nop};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      first_exec_q <= 1'b0;
      bp_hit_q     <= 1'b0;
      cycle_cnt_q  <= 16'h0000;
      instr_cnt_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      first_exec_q <= first_exec_d;
      bp_hit_q     <= bp_hit_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  assign state_o     = exec ? ST_EXEC : ST_IDLE;
  assign halted_o    = (state_q == S_HALTED);
  assign bp_hit_o    = bp_hit_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule
